// File: rtl/axis_vec_joinn.sv
// axis_vec_joinn: N-way vector stream join, one FIFO per input channel.
// Define JOIN_OUT_REG_EN to add a one-entry registered output stage.
module axis_vec_joinn #(
    parameter int NUM_CH     = 3,
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int VW        = TILE_SIZE * DATA_WIDTH,
    localparam int BW        = NUM_CH * VW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           in_ready,
    input  logic [NUM_CH-1:0]           in_last,
    input  logic [BW-1:0]               in_vec,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BW-1:0]               out_vec,
    output logic                        out_last,
    output logic                        err_last,
    output logic [NUM_CH*(PTR_W+1)-1:0] fill
);

    localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_C = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] ONE_P = PTR_W'(1);

    logic [VW-1:0]    mem_vec  [NUM_CH][DEPTH];
    logic [DEPTH-1:0] mem_last [NUM_CH];
    logic [PTR_W-1:0] wr       [NUM_CH];
    logic [PTR_W-1:0] rd       [NUM_CH];
    logic [PTR_W:0]   cnt      [NUM_CH];

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] head_last;
    logic [BW-1:0]     head_vec;
    logic              all_ne;
    logic              fifo_pop;
    logic              last_ok;

    // Per-channel ready/push, FIFO heads and fill levels
    always_comb begin
        in_ready  = '0;
        push      = '0;
        nonempty  = '0;
        head_last = '0;
        head_vec  = '0;
        fill      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready[c]  = (cnt[c] < FULL) && !flush;
            push[c]      = in_valid[c] && in_ready[c];
            nonempty[c]  = (cnt[c] != '0);
            head_last[c] = mem_last[c][rd[c]];
            head_vec[c*VW +: VW] = mem_vec[c][rd[c]];
            fill[c*(PTR_W+1) +: PTR_W+1] = cnt[c];
        end
    end

    assign all_ne  = &nonempty;
    assign last_ok = (&head_last) || !(|head_last);

`ifdef JOIN_OUT_REG_EN
    logic          ov_q;
    logic          ol_q;
    logic [BW-1:0] ovec_q;

    assign fifo_pop = all_ne && (!ov_q || out_ready);

    // Output stage: refill from the heads when empty or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q   <= 1'b0;
            ol_q   <= 1'b0;
            ovec_q <= '0;
        end else if (flush) begin
            ov_q   <= 1'b0;
            ol_q   <= 1'b0;
            ovec_q <= '0;
        end else if (fifo_pop) begin
            ov_q   <= 1'b1;
            ol_q   <= &head_last;
            ovec_q <= head_vec;
        end else if (out_ready) begin
            ov_q   <= 1'b0;
        end
    end

    assign out_valid = ov_q;
    assign out_vec   = ovec_q;
    assign out_last  = ol_q;
`else
    assign fifo_pop  = all_ne && out_ready;
    assign out_valid = all_ne;
    assign out_vec   = all_ne ? head_vec : '0;
    assign out_last  = all_ne && (&head_last);
`endif

    // Pointers, occupancy and sticky last-mismatch flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr[c]  <= '0;
                rd[c]  <= '0;
                cnt[c] <= '0;
            end
            err_last <= 1'b0;
        end else if (flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr[c]  <= '0;
                rd[c]  <= '0;
                cnt[c] <= '0;
            end
            err_last <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c])
                    wr[c] <= wr[c] + ONE_P;
                if (fifo_pop)
                    rd[c] <= rd[c] + ONE_P;
                unique case ({push[c], fifo_pop})
                    2'b10:   cnt[c] <= cnt[c] + ONE_C;
                    2'b01:   cnt[c] <= cnt[c] - ONE_C;
                    default: cnt[c] <= cnt[c];
                endcase
            end
            if (fifo_pop && !last_ok)
                err_last <= 1'b1;
        end
    end

    // FIFO storage write; contents need no reset
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem_vec[c][wr[c]]  <= in_vec[c*VW +: VW];
                mem_last[c][wr[c]] <= in_last[c];
            end
        end
    end

endmodule
